pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Next-PC controller for the 5-stage RV32 pipeline. It owns the architectural fetch PC and decides each cycle among these actions:
- sequential increment
- branch/jump redirect
- trap redirect
- hazard stall
- instruction-memory wait

It drives the fetch address and the IF/ID and ID/EX flush controls. It sits between the hazard/branch units and the instruction memory.

Parameters:
RESET_VEC, 32'h0000_0000, PC value loaded on reset.
XLEN, 32, address width; only 32 is supported.

Ports:
clk  in  1  pipeline clock; all state updates on rising edge.
rst  in  1  asynchronous reset, active-low (rst=0 resets the block).
stall  in  1  load-use hazard from the hazard unit; hold PC.
br_taken  in  1  branch resolved taken in EX.
br_target  in  32  branch target.
jmp  in  1  JAL/JALR resolved in EX.
jmp_target  in  32  jump target.
trap  in  1  exception/ecall request.
trap_vec  in  32  trap handler address.
imem_ready  in  1  instruction memory has returned data for pc_out.
pc_out  out  32  current fetch address.
fetch_valid  out  1  pc_out is a real fetch request.
pc_en  out  1  PC advanced at this edge (IF/ID load enable).
flush_if_id  out  1  kill instruction in IF/ID.
flush_id_ex  out  1  kill instruction in ID/EX.
misalign  out  1  redirect target had bits[1:0]!=0; diverted to trap_vec.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc_out=RESET_VEC, state=BOOT.
  - fetch_valid=0, pc_en=0, flush_*=0, misalign=0.
  - Pending redirect cleared.
  - Reset mid-WAIT or mid-redirect discards everything.
- States: BOOT, RUN, WAIT_MEM.
- BOOT: one cycle after rst release, go to RUN with fetch_valid=1. pc_out stays RESET_VEC, so the first fetch is RESET_VEC, not RESET_VEC+4.
- Redirect selection (combinational, RUN or WAIT_MEM):
  - Priority is trap > jmp > br_taken.
  - Target is trap_vec, jmp_target or br_target respectively.
  - A jmp/br target with [1:0]!=0 is replaced by trap_vec. misalign=1 for that cycle.
- Flushes:
  - flush_if_id=flush_id_ex=1 combinationally in the cycle a redirect is accepted.
  - A trap additionally flushes regardless of stall.
- RUN, evaluated in this order at each edge:
  1. Redirect: pc_out<=target, pc_en=1. Stall is ignored because the redirect wins.
  2. Else if stall=1: pc_out held, pc_en=0, no flush.
  3. Else if imem_ready=0: pc_out held, pc_en=0, go to WAIT_MEM, fetch_valid stays 1.
  4. Else: pc_out<=pc_out+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0), pc_en=1.
- WAIT_MEM:
  - pc_out held, fetch_valid=1, pc_en=0.
  - A redirect arriving while imem_ready=0 is latched into pend_target/pend_valid. Flushes assert that cycle.
  - A later redirect overwrites the pending one, using the same priority.
  - On imem_ready=1 with pend_valid: pc_out<=pend_target, flush_if_id=1 (returned instruction discarded), pend_valid<=0, go to RUN.
  - On imem_ready=1 without pending and with a same-cycle redirect: treat as the RUN redirect case.
  - On imem_ready=1 otherwise: apply the RUN rules (stall may still hold the PC), go to RUN.
- pc_en is combinational from state and inputs. It is 1 exactly on edges where pc_out changes.
- There are no other hidden latencies: a redirect's target appears on pc_out one cycle after the request.

Test Plan:
1. rst low then released; imem_ready=1, no hazards for 4 cycles -> pc_out sequence 0,0,4,8,C. fetch_valid=0 during reset and 1 from the BOOT exit.
2. At pc_out=0x10, br_taken=1 with br_target=0x40, and stall=1 the same cycle -> flush_if_id=flush_id_ex=1 that cycle; next pc_out=0x40.
3. stall=1 for 2 cycles at pc_out=0x20 -> pc_out stays 0x20, pc_en=0 for both cycles; then 0x24.
4. imem_ready=0 for 3 cycles at 0x30; jmp=1 with jmp_target=0x100 in the 2nd wait cycle; then imem_ready=1 -> pc_out 0x30 held; next pc_out=0x100 with flush_if_id=1 in the ready cycle.
5. jmp=1 with jmp_target=0x102 together with br_taken; trap_vec=0x80 -> misalign=1, next pc_out=0x80. Separately, trap=1 and jmp=1 together -> pc_out=trap_vec.
6. Force pc_out=0xFFFF_FFFC via trap_vec, then run one cycle -> pc_out=0x0000_0000. Assert rst=0 in WAIT_MEM with a pending redirect -> immediate pc_out=RESET_VEC, pending lost.

Source files
------------

// File: rtl/pc_sequencer.sv
// Next-PC controller for the 5-stage RV32 pipeline: owns the fetch PC and arbitrates
// sequential fetch, branch/jump/trap redirects, load-use stalls and instruction-memory waits.
module pc_sequencer #(
   parameter logic [31:0] RESET_VEC = 32'h0000_0000,
   parameter int          XLEN      = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            br_taken,
   input  logic [XLEN-1:0] br_target,
   input  logic            jmp,
   input  logic [XLEN-1:0] jmp_target,
   input  logic            trap,
   input  logic [XLEN-1:0] trap_vec,
   input  logic            imem_ready,
   output logic [XLEN-1:0] pc_out,
   output logic            fetch_valid,
   output logic            pc_en,
   output logic            flush_if_id,
   output logic            flush_id_ex,
   output logic            misalign
);

   typedef enum logic [1:0] {
      BOOT     = 2'd0,
      RUN      = 2'd1,
      WAIT_MEM = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pend_target_q, pend_target_d;
   logic            pend_valid_q, pend_valid_d;
   logic            redir_s;
   logic            redir_mis_s;
   logic [XLEN-1:0] redir_tgt_s;

   // Redirect arbitration: trap > jmp > branch; a misaligned jump/branch target falls back to trap_vec.
   always_comb begin
      redir_s     = 1'b0;
      redir_mis_s = 1'b0;
      redir_tgt_s = pc_q;
      if (trap) begin
         redir_s     = 1'b1;
         redir_tgt_s = trap_vec;
      end else if (jmp) begin
         redir_s = 1'b1;
         if (jmp_target[1:0] != 2'b00) begin
            redir_mis_s = 1'b1;
            redir_tgt_s = trap_vec;
         end else begin
            redir_tgt_s = jmp_target;
         end
      end else if (br_taken) begin
         redir_s = 1'b1;
         if (br_target[1:0] != 2'b00) begin
            redir_mis_s = 1'b1;
            redir_tgt_s = trap_vec;
         end else begin
            redir_tgt_s = br_target;
         end
      end else begin
         redir_s = 1'b0;
      end
   end

   // Next-state, next-PC and the combinational pipeline controls.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      pend_target_d = pend_target_q;
      pend_valid_d  = pend_valid_q;
      pc_en         = 1'b0;
      flush_if_id   = 1'b0;
      flush_id_ex   = 1'b0;
      misalign      = 1'b0;
      case (state_q)
         BOOT: begin
            state_d = RUN;
         end
         RUN: begin
            if (redir_s) begin
               pc_d        = redir_tgt_s;
               pc_en       = 1'b1;
               flush_if_id = 1'b1;
               flush_id_ex = 1'b1;
               misalign    = redir_mis_s;
            end else if (stall) begin
               pc_d = pc_q;
            end else if (!imem_ready) begin
               state_d = WAIT_MEM;
            end else begin
               pc_d  = pc_q + 32'd4;
               pc_en = 1'b1;
            end
         end
         WAIT_MEM: begin
            if (redir_s) begin
               flush_if_id = 1'b1;
               flush_id_ex = 1'b1;
               misalign    = redir_mis_s;
               if (imem_ready) begin
                  pc_d         = redir_tgt_s;
                  pc_en        = 1'b1;
                  pend_valid_d = 1'b0;
                  state_d      = RUN;
               end else begin
                  pend_target_d = redir_tgt_s;
                  pend_valid_d  = 1'b1;
               end
            end else if (imem_ready) begin
               state_d      = RUN;
               pend_valid_d = 1'b0;
               // The word returned for the stale fetch is dropped in favour of the held redirect.
               if (pend_valid_q) begin
                  pc_d        = pend_target_q;
                  pc_en       = 1'b1;
                  flush_if_id = 1'b1;
               end else if (!stall) begin
                  pc_d  = pc_q + 32'd4;
                  pc_en = 1'b1;
               end else begin
                  pc_d = pc_q;
               end
            end else begin
               pc_d = pc_q;
            end
         end
         default: begin
            state_d      = BOOT;
            pend_valid_d = 1'b0;
         end
      endcase
   end

   // State, PC and pending-redirect registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= BOOT;
         pc_q          <= RESET_VEC;
         pend_target_q <= RESET_VEC;
         pend_valid_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         pend_target_q <= pend_target_d;
         pend_valid_q  <= pend_valid_d;
      end
   end

   assign pc_out      = pc_q;
   assign fetch_valid = (state_q != BOOT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector tables for the listed scenarios, an async-reset
// sequence, then randomized traffic checked against a rule-level reference model.
module tb_pc_sequencer;

   localparam logic [31:0] RV = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, br_taken, jmp, trap, imem_ready;
   logic [31:0] br_target, jmp_target, trap_vec;
   logic [31:0] pc_out;
   logic        fetch_valid, pc_en, flush_if_id, flush_id_ex, misalign;

   always #5 clk = ~clk;

   pc_sequencer #(.RESET_VEC(RV), .XLEN(32)) dut (
      .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_target(br_target),
      .jmp(jmp), .jmp_target(jmp_target), .trap(trap), .trap_vec(trap_vec),
      .imem_ready(imem_ready), .pc_out(pc_out), .fetch_valid(fetch_valid), .pc_en(pc_en),
      .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .misalign(misalign)
   );

   typedef struct {
      logic        st;
      logic        br;
      logic [31:0] bt;
      logic        jm;
      logic [31:0] jt;
      logic        tr;
      logic [31:0] tv;
      logic        rdy;
      logic [31:0] e_pc;
      logic        e_fv;
      logic        e_en;
      logic        e_f1;
      logic        e_f2;
      logic        e_mis;
   } vec_t;

   int checks = 0;
   int errors = 0;

   // Reference model state: boot flag, PC, outstanding-fetch flag, held redirect.
   bit          m_boot;
   bit          m_wait;
   logic [31:0] m_pc;
   logic [31:0] pend[$];

   function automatic vec_t mk(input logic st, br, input logic [31:0] bt, input logic jm,
                               input logic [31:0] jt, input logic tr, input logic [31:0] tv,
                               input logic rdy, input logic [31:0] pc,
                               input logic fv, en, f1, f2, mis);
      vec_t v;
      v.st = st; v.br = br; v.bt = bt; v.jm = jm; v.jt = jt; v.tr = tr; v.tv = tv; v.rdy = rdy;
      v.e_pc = pc; v.e_fv = fv; v.e_en = en; v.e_f1 = f1; v.e_f2 = f2; v.e_mis = mis;
      return v;
   endfunction

   function automatic vec_t idle(input logic rdy, input logic st, input logic [31:0] pc,
                                 input logic fv, en);
      return mk(st, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, rdy, pc, fv, en, 1'b0, 1'b0, 1'b0);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      stall = v.st; br_taken = v.br; br_target = v.bt; jmp = v.jm; jmp_target = v.jt;
      trap = v.tr; trap_vec = v.tv; imem_ready = v.rdy;
   endtask

   task automatic run_row(input vec_t v);
      drive(v);
      @(negedge clk);
      chk("pc_out", pc_out, v.e_pc);
      chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, v.e_fv});
      chk("pc_en", {31'd0, pc_en}, {31'd0, v.e_en});
      chk("flush_if_id", {31'd0, flush_if_id}, {31'd0, v.e_f1});
      chk("flush_id_ex", {31'd0, flush_id_ex}, {31'd0, v.e_f2});
      chk("misalign", {31'd0, misalign}, {31'd0, v.e_mis});
      @(posedge clk);
      #1;
   endtask

   // Resolve the redirect a set of requests asks for, straight from the priority rules.
   function automatic void pick(input logic t, j, b, input logic [31:0] tv, jt, bt,
                                output bit hit, output logic [31:0] dest, output bit bad);
      hit  = t | j | b;
      bad  = 1'b0;
      dest = t ? tv : (j ? jt : (b ? bt : 32'h0));
      if (hit && !t && dest[1:0] != 2'b00) begin
         bad  = 1'b1;
         dest = tv;
      end
   endfunction

   function automatic logic [31:0] rnd_tgt();
      logic [31:0] t;
      t = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(3, 0) == 0) t = t | ($urandom() & 32'h0000_0003);
      return t;
   endfunction

   vec_t tbl1[$];
   vec_t tbl2[$];

   initial begin
      rst = 1'b0;
      drive(idle(1'b1, 1'b0, RV, 1'b0, 1'b0));

      // Scenarios 1-6a: boot, branch under stall, stall hold, wait with jump, misalign, wrap.
      tbl1.push_back(idle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0));
      tbl1.push_back(idle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1));
      tbl1.push_back(idle(1'b1, 1'b0, 32'h4, 1'b1, 1'b1));
      tbl1.push_back(idle(1'b1, 1'b0, 32'h8, 1'b1, 1'b1));
      tbl1.push_back(idle(1'b1, 1'b0, 32'hC, 1'b1, 1'b1));
      tbl1.push_back(mk(1, 1, 32'h40, 0, 32'h0, 0, 32'h0, 1, 32'h10, 1, 1, 1, 1, 0));
      tbl1.push_back(mk(0, 0, 32'h0, 1, 32'h20, 0, 32'h0, 1, 32'h40, 1, 1, 1, 1, 0));
      tbl1.push_back(idle(1'b1, 1'b1, 32'h20, 1'b1, 1'b0));
      tbl1.push_back(idle(1'b1, 1'b1, 32'h20, 1'b1, 1'b0));
      tbl1.push_back(idle(1'b1, 1'b0, 32'h20, 1'b1, 1'b1));
      tbl1.push_back(mk(0, 1, 32'h30, 0, 32'h0, 0, 32'h0, 1, 32'h24, 1, 1, 1, 1, 0));
      tbl1.push_back(idle(1'b0, 1'b0, 32'h30, 1'b1, 1'b0));
      tbl1.push_back(mk(0, 0, 32'h0, 1, 32'h100, 0, 32'h0, 0, 32'h30, 1, 0, 1, 1, 0));
      tbl1.push_back(idle(1'b0, 1'b0, 32'h30, 1'b1, 1'b0));
      tbl1.push_back(mk(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 32'h30, 1, 1, 1, 0, 0));
      tbl1.push_back(idle(1'b1, 1'b0, 32'h100, 1'b1, 1'b1));
      tbl1.push_back(mk(0, 1, 32'h200, 1, 32'h102, 0, 32'h80, 1, 32'h104, 1, 1, 1, 1, 1));
      tbl1.push_back(mk(0, 0, 32'h0, 1, 32'h400, 1, 32'h300, 1, 32'h80, 1, 1, 1, 1, 0));
      tbl1.push_back(mk(0, 0, 32'h0, 0, 32'h0, 1, 32'hFFFF_FFFC, 1, 32'h300, 1, 1, 1, 1, 0));
      tbl1.push_back(idle(1'b1, 1'b0, 32'hFFFF_FFFC, 1'b1, 1'b1));
      tbl1.push_back(idle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1));
      tbl1.push_back(idle(1'b0, 1'b0, 32'h4, 1'b1, 1'b0));
      tbl1.push_back(mk(0, 1, 32'h500, 0, 32'h0, 0, 32'h0, 0, 32'h4, 1, 0, 1, 1, 0));

      // After the mid-wait reset: fresh boot, pending overwrite, pending beats stall,
      // stalled wait exit, and a redirect landing in the ready cycle of a wait.
      tbl2.push_back(idle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0));
      tbl2.push_back(idle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1));
      tbl2.push_back(idle(1'b0, 1'b0, 32'h4, 1'b1, 1'b0));
      tbl2.push_back(mk(0, 1, 32'h600, 0, 32'h0, 0, 32'h0, 0, 32'h4, 1, 0, 1, 1, 0));
      tbl2.push_back(mk(0, 0, 32'h0, 1, 32'h800, 1, 32'h700, 0, 32'h4, 1, 0, 1, 1, 0));
      tbl2.push_back(mk(1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 32'h4, 1, 1, 1, 0, 0));
      tbl2.push_back(idle(1'b0, 1'b0, 32'h700, 1'b1, 1'b0));
      tbl2.push_back(idle(1'b1, 1'b1, 32'h700, 1'b1, 1'b0));
      tbl2.push_back(idle(1'b1, 1'b0, 32'h700, 1'b1, 1'b1));
      tbl2.push_back(idle(1'b0, 1'b0, 32'h704, 1'b1, 1'b0));
      tbl2.push_back(mk(0, 0, 32'h0, 1, 32'h900, 0, 32'h0, 1, 32'h704, 1, 1, 1, 1, 0));
      tbl2.push_back(idle(1'b1, 1'b0, 32'h900, 1'b1, 1'b1));

      repeat (2) @(posedge clk);
      #2;
      chk("reset pc_out", pc_out, RV);
      chk("reset fetch_valid", {31'd0, fetch_valid}, 32'd0);
      chk("reset pc_en", {31'd0, pc_en}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      foreach (tbl1[i]) run_row(tbl1[i]);

      // Asynchronous reset while a redirect is held in the wait state.
      rst = 1'b0;
      #1;
      chk("async rst pc_out", pc_out, RV);
      chk("async rst fetch_valid", {31'd0, fetch_valid}, 32'd0);
      chk("async rst flush_if_id", {31'd0, flush_if_id}, 32'd0);
      drive(idle(1'b1, 1'b0, RV, 1'b0, 1'b0));
      @(posedge clk);
      #1;
      rst = 1'b1;
      foreach (tbl2[i]) run_row(tbl2[i]);

      // Randomized traffic against the reference model; occasional resets.
      for (int n = 0; n < 3000; n++) begin
         vec_t        v;
         bit          hit, bad, nwait;
         logic [31:0] dest, npc;
         v.st  = ($urandom_range(9, 0) < 2);
         v.br  = ($urandom_range(9, 0) == 0);
         v.jm  = ($urandom_range(11, 0) == 0);
         v.tr  = ($urandom_range(24, 0) == 0);
         v.rdy = ($urandom_range(9, 0) < 7);
         v.bt  = rnd_tgt();
         v.jt  = rnd_tgt();
         v.tv  = $urandom() & 32'hFFFF_FFFC;
         if (n == 0 || $urandom_range(199, 0) == 0) begin
            rst    = 1'b0;
            m_boot = 1'b1;
            m_wait = 1'b0;
            m_pc   = RV;
            pend.delete();
            v.e_pc = RV; v.e_fv = 1'b0; v.e_en = 1'b0;
            v.e_f1 = 1'b0; v.e_f2 = 1'b0; v.e_mis = 1'b0;
            run_row(v);
            rst = 1'b1;
            continue;
         end
         v.e_pc = m_pc; v.e_fv = !m_boot; v.e_en = 1'b0;
         v.e_f1 = 1'b0; v.e_f2 = 1'b0; v.e_mis = 1'b0;
         npc   = m_pc;
         nwait = m_wait;
         if (!m_boot) begin
            pick(v.tr, v.jm, v.br, v.tv, v.jt, v.bt, hit, dest, bad);
            if (hit) begin
               v.e_f1 = 1'b1; v.e_f2 = 1'b1; v.e_mis = bad;
               pend.delete();
               if (!m_wait || v.rdy) begin
                  npc = dest; v.e_en = 1'b1; nwait = 1'b0;
               end else begin
                  pend.push_back(dest);
               end
            end else if (m_wait) begin
               if (v.rdy) begin
                  nwait = 1'b0;
                  if (pend.size() > 0) begin
                     npc = pend.pop_front(); v.e_en = 1'b1; v.e_f1 = 1'b1;
                  end else if (!v.st) begin
                     npc = m_pc + 32'd4; v.e_en = 1'b1;
                  end
               end
            end else if (!v.st) begin
               if (!v.rdy) nwait = 1'b1;
               else begin
                  npc = m_pc + 32'd4; v.e_en = 1'b1;
               end
            end
         end
         run_row(v);
         m_boot = 1'b0;
         m_pc   = npc;
         m_wait = nwait;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
